// File: rtl/pkt_sink_checker.sv
// pkt_sink_checker
//
// Packet sink for one mesh node. It accepts packets while running, registers
// each accepted packet into a one-entry capture stage, and checks that stage on
// the following edge for destination, source and per-source ordering errors.
// The run ends after num_expected accepts or when i_enable falls.
//
// Ports
//   clk               single clock
//   rst               synchronous active-high reset
//   i_data            packet, LSB first: dest_x, dest_y, src_x, src_y, payload
//   i_valid           packet present on i_data
//   o_ready           sink takes i_data at the next clk edge
//   i_enable          run permission
//   o_rcv_count       checked packets (saturating)
//   o_err_dest_count  packets addressed to another node (saturating)
//   o_err_src_count   packets with an out-of-mesh source (saturating)
//   o_err_order_count packets out of sequence for their source (saturating)
//   o_first_err       sticky {order, src, dest} code of the first bad packet
//   o_err             any error seen
//   o_done            run finished and capture stage empty
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for i_enable, not ready
// RUN   | accepting packets, optional periodic backpressure
// DRAIN | enable dropped, waiting for the capture stage to empty
// DONE  | run finished, held until rst
module pkt_sink_checker #(
   parameter int xcord        = 0,
   parameter int ycord        = 0,
   parameter int X            = 4,
   parameter int Y            = 4,
   parameter int dest_x       = 2,
   parameter int dest_y       = 2,
   parameter int source_x     = 8,
   parameter int source_y     = 8,
   parameter int data_width   = 240,
   parameter int total_width  = dest_x + dest_y + source_x + source_y + data_width,
   parameter int seq_width    = 16,
   parameter int stall_period = 0,
   parameter int num_expected = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [total_width-1:0] i_data,
   input  logic                   i_valid,
   output logic                   o_ready,
   input  logic                   i_enable,
   output logic [31:0]            o_rcv_count,
   output logic [31:0]            o_err_dest_count,
   output logic [31:0]            o_err_src_count,
   output logic [31:0]            o_err_order_count,
   output logic [2:0]             o_first_err,
   output logic                   o_err,
   output logic                   o_done
);

   localparam int DX_LSB = 0;
   localparam int DY_LSB = DX_LSB + dest_x;
   localparam int SX_LSB = DY_LSB + dest_y;
   localparam int SY_LSB = SX_LSB + source_x;
   localparam int PL_LSB = SY_LSB + source_y;
   localparam int CW     = PL_LSB + seq_width;
   localparam int NPE    = X * Y;
   localparam int IW     = (NPE > 1) ? $clog2(NPE) : 1;

   localparam logic [31:0]         SP_M1   = (stall_period > 0) ? 32'(stall_period - 1) : 32'd0;
   localparam logic [31:0]         NUM_EXP = 32'(num_expected);
   localparam logic [31:0]         X_LIM   = 32'(X);
   localparam logic [31:0]         Y_LIM   = 32'(Y);
   localparam logic [dest_x-1:0]   XC      = dest_x'(xcord);
   localparam logic [dest_y-1:0]   YC      = dest_y'(ycord);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [31:0]     stall_q, stall_d;
   logic [31:0]     acc_cnt_q, acc_cnt_d;
   logic            cap_valid_q, cap_valid_d;
   logic [CW-1:0]   cap_data_q, cap_data_d;
   logic [31:0]     rcv_q, rcv_d;
   logic [31:0]     dest_cnt_q, dest_cnt_d;
   logic [31:0]     src_cnt_q, src_cnt_d;
   logic [31:0]     ord_cnt_q, ord_cnt_d;
   logic [2:0]      first_err_q, first_err_d;

   logic                 seen_q [NPE];
   logic [seq_width-1:0] last_q [NPE];

   // Only the header and the sequence field are ever inspected.
   logic unused_payload;
   assign unused_payload = ^i_data[total_width-1:CW];

   function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
      return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
   endfunction

   logic ready_w;
   logic accept;

   assign ready_w = (state_q == S_RUN) && ((stall_period == 0) || (stall_q != SP_M1));
   assign accept  = i_valid & ready_w;

   // ---------------- check stage ----------------
   logic [dest_x-1:0]    f_dx;
   logic [dest_y-1:0]    f_dy;
   logic [source_x-1:0]  f_sx;
   logic [source_y-1:0]  f_sy;
   logic [seq_width-1:0] f_seq;
   logic [IW-1:0]        idx;
   logic [seq_width-1:0] seq_diff;
   logic                 dest_err, src_err, in_order, order_err, tbl_we;
   logic [2:0]           ecode;

   assign f_dx  = cap_data_q[DX_LSB +: dest_x];
   assign f_dy  = cap_data_q[DY_LSB +: dest_y];
   assign f_sx  = cap_data_q[SX_LSB +: source_x];
   assign f_sy  = cap_data_q[SY_LSB +: source_y];
   assign f_seq = cap_data_q[PL_LSB +: seq_width];

   assign idx      = IW'(32'(f_sy) * X_LIM + 32'(f_sx));
   assign dest_err = (f_dx != XC) || (f_dy != YC);
   assign src_err  = (32'(f_sx) >= X_LIM) || (32'(f_sy) >= Y_LIM);

   // Forward distance modulo 2^seq_width must be nonzero and under half range;
   // this makes all-ones -> 0 a valid step and rejects duplicates.
   assign seq_diff  = f_seq - last_q[idx];
   assign in_order  = (seq_diff != '0) && !seq_diff[seq_width-1];
   assign order_err = !src_err && seen_q[idx] && !in_order;
   assign tbl_we    = cap_valid_q && !src_err;
   assign ecode     = {order_err, src_err, dest_err};

   always_comb begin
      state_d     = state_q;
      stall_d     = stall_q;
      acc_cnt_d   = acc_cnt_q;
      cap_valid_d = accept;
      cap_data_d  = accept ? i_data[CW-1:0] : cap_data_q;

      case (state_q)
         S_IDLE: begin
            if (i_enable) state_d = S_RUN;
         end
         S_RUN: begin
            if (stall_period != 0) begin
               stall_d = (stall_q == SP_M1) ? 32'd0 : stall_q + 32'd1;
            end
            if (accept) acc_cnt_d = sat_inc(acc_cnt_q, 1'b1);
            if (accept && (acc_cnt_q + 32'd1 == NUM_EXP)) begin
               state_d = S_DONE;
            end else if (!i_enable) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (!cap_valid_q) state_d = S_DONE;
         end
         default: ;
      endcase

      rcv_d       = sat_inc(rcv_q,      cap_valid_q);
      dest_cnt_d  = sat_inc(dest_cnt_q, cap_valid_q & dest_err);
      src_cnt_d   = sat_inc(src_cnt_q,  cap_valid_q & src_err);
      ord_cnt_d   = sat_inc(ord_cnt_q,  cap_valid_q & order_err);
      first_err_d = (cap_valid_q && (first_err_q == 3'b000)) ? ecode : first_err_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         stall_q     <= '0;
         acc_cnt_q   <= '0;
         cap_valid_q <= 1'b0;
         cap_data_q  <= '0;
         rcv_q       <= '0;
         dest_cnt_q  <= '0;
         src_cnt_q   <= '0;
         ord_cnt_q   <= '0;
         first_err_q <= '0;
      end else begin
         state_q     <= state_d;
         stall_q     <= stall_d;
         acc_cnt_q   <= acc_cnt_d;
         cap_valid_q <= cap_valid_d;
         cap_data_q  <= cap_data_d;
         rcv_q       <= rcv_d;
         dest_cnt_q  <= dest_cnt_d;
         src_cnt_q   <= src_cnt_d;
         ord_cnt_q   <= ord_cnt_d;
         first_err_q <= first_err_d;
      end
   end

   // Table write lands on the check edge, so the next back-to-back packet
   // from the same source already reads the updated entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NPE; i++) begin
            seen_q[i] <= 1'b0;
            last_q[i] <= '0;
         end
      end else if (tbl_we) begin
         seen_q[idx] <= 1'b1;
         last_q[idx] <= f_seq;
      end
   end

   assign o_ready           = ready_w;
   assign o_rcv_count       = rcv_q;
   assign o_err_dest_count  = dest_cnt_q;
   assign o_err_src_count   = src_cnt_q;
   assign o_err_order_count = ord_cnt_q;
   assign o_first_err       = first_err_q;
   assign o_err             = (first_err_q != 3'b000);
   assign o_done            = (state_q == S_DONE) && !cap_valid_q;

endmodule
